// File: rtl/serial_and_unit.sv
// Bit-serial bitwise AND of two WIDTH-bit operands, LSB first, with valid/ready on both sides.
// Define SERIAL_AND_UNIT_OPSEL_EN to add an op port selecting AND / OR / XOR / A AND NOT B.
module serial_and_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_AND_UNIT_OPSEL_EN
    input  logic [1:0]       op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             bit_v;
    logic [WIDTH:0]   res_cat;
`ifdef SERIAL_AND_UNIT_OPSEL_EN
    logic [1:0]       op_r;
`endif

    // One result bit per SHIFT edge from the current LSBs of the operand shifters.
    always_comb begin
        bit_v = 1'b0;
`ifdef SERIAL_AND_UNIT_OPSEL_EN
        case (op_r)
            2'b00:   bit_v = a_sh[0] & b_sh[0];
            2'b01:   bit_v = a_sh[0] | b_sh[0];
            2'b10:   bit_v = a_sh[0] ^ b_sh[0];
            default: bit_v = a_sh[0] & ~b_sh[0];
        endcase
`else
        bit_v = a_sh[0] & b_sh[0];
`endif
    end

    // New bit enters the MSB so the first computed bit ends up in c[0] after WIDTH shifts.
    assign res_cat  = {bit_v, res};
    assign in_ready = (state == IDLE) && !rst;
    assign c        = res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_AND_UNIT_OPSEL_EN
            op_r      <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_AND_UNIT_OPSEL_EN
                        op_r  <= op;
`endif
                    end
                end
                SHIFT: begin
                    res  <= res_cat[WIDTH:1];
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
